dcache_stall_ctrl: RTL
======================

Name: dcache_stall_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache front end for the memory (M) stage of the pipelined RV32I core.
- Serves loads on hit with zero stall.
- On a load miss or any store, raises a stall request into the hazard unit, runs a req/ack handshake to backing data memory, then releases the pipeline.
- This block is the producer of memory-stage stall requests; the hazard unit consumes them.

Parameters:
- LINES, 16, number of one-word cache lines; power of 2, at least 2.
- DATA_WIDTH, 32, word width.
- PERF_WIDTH, 16, width of the wrapping performance counters.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous, active-low reset.
- MemReadM  input  1  M-stage instruction is a load.
- MemWriteM  input  1  M-stage instruction is a store.
- AddrM  input  32  byte address of the M-stage access.
- WriteDataM  input  DATA_WIDTH  store data.
- ReadDataM  output  DATA_WIDTH  load data returned to the W-stage pipeline register.
- StallReqM  output  1  request to freeze F/D/E/M to the hazard unit.
- mem_req  output  1  backing-memory request, registered.
- mem_we  output  1  1 = write, 0 = read, registered.
- mem_addr  output  32  word-aligned request address, registered.
- mem_wdata  output  DATA_WIDTH  store data, registered.
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack.
- mem_ack  input  1  single-cycle completion strobe.
- perf_hits  output  PERF_WIDTH  load-hit count.
- perf_misses  output  PERF_WIDTH  load-miss count.

Behaviour:
- Address split:
  - IB = log2(LINES).
  - index = AddrM[IB+1:2].
  - tag = AddrM[31:IB+2].
  - AddrM[1:0] are ignored; accesses are word only.
  - mem_addr = {AddrM[31:2], 2'b00}, latched on miss/store detection.
- Storage per line: valid bit, tag, data. Data and tag are not reset. Valid bits clear on reset.
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESUME.
- IDLE:
  - MemWriteM has priority if both MemReadM and MemWriteM are asserted.
  - MemWriteM:
    - StallReqM = 1, combinational, same cycle.
    - Latch address and data.
    - On tag hit with valid set, update line data at this edge.
    - Next state WR_WAIT.
  - MemReadM with valid and tag match:
    - ReadDataM = line data, combinational.
    - StallReqM = 0.
    - perf_hits += 1.
    - Stay in IDLE.
  - MemReadM miss:
    - StallReqM = 1, combinational.
    - Latch address.
    - perf_misses += 1.
    - Next state RD_WAIT.
  - Otherwise ReadDataM = 0 and StallReqM = 0.
- RD_WAIT:
  - mem_req = 1, mem_we = 0, StallReqM = 1.
  - On mem_ack: write line data = mem_rdata, write tag, set valid, capture mem_rdata in a hold register, go to RESUME.
- WR_WAIT:
  - mem_req = 1, mem_we = 1, StallReqM = 1.
  - On mem_ack go to RESUME.
- RESUME:
  - StallReqM = 0, mem_req = 0.
  - ReadDataM = hold register after a read, 0 after a write.
  - MemReadM/MemWriteM are ignored this cycle, because the same instruction is still in M.
  - Next state IDLE unconditionally.
- Handshake rules:
  - mem_req, mem_we, mem_addr, mem_wdata stay stable from assertion until the cycle mem_ack is sampled high.
  - mem_req is deasserted the cycle after ack.
  - mem_ack in IDLE or RESUME is ignored.
- Latency:
  - Read hit: 0 stall cycles.
  - Miss or store detected at cycle T: mem_req rises at T+1.
  - If ack arrives k cycles after T+1 (k ≥ 0), RESUME is at T+2+k.
  - Total stall = 2+k cycles.
- Counters wrap at 2^PERF_WIDTH. Stores do not count.
- Reset:
  - Asynchronous, at any point including mid-transaction.
  - State goes to IDLE.
  - All valid bits, mem_req, mem_we, StallReqM, ReadDataM, counters, mem_addr, mem_wdata and hold register go to 0.
  - A pending memory transaction is abandoned. The memory model must tolerate this.
- Aliasing: a refill to an index overwrites the resident line regardless of its tag. Being write-through, eviction needs no writeback.

Test Plan:
- Reset, then load 0x0000_0040, ack after 3 cycles with 0xDEADBEEF:
  - StallReqM high for 5 cycles.
  - mem_addr = 0x40, mem_we = 0.
  - ReadDataM = 0xDEADBEEF in RESUME.
  - perf_misses = 1.
- Repeat load 0x40:
  - No stall, ReadDataM = 0xDEADBEEF same cycle.
  - perf_hits = 1.
- Store 0x12345678 to 0x40 with ack k = 0:
  - 2-cycle stall, mem_we = 1, mem_wdata = 0x12345678.
  - A following load of 0x40 hits with 0x12345678.
- Store to uncached 0x80, then load 0x80:
  - Store stalls 2+k cycles and does not allocate.
  - The load misses (perf_misses increments).
- Load 0x40, then load 0x440 (same index 0 for LINES = 16, different tag), then load 0x40:
  - Third access misses again (eviction).
- Assert rst_n = 0 during RD_WAIT:
  - mem_req and StallReqM drop immediately.
  - The next load of the same address misses.

Source files
------------

// File: rtl/dcache_stall_ctrl.sv
// dcache_stall_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache front end for
//   the M stage. Load hits return data combinationally with no stall. Load
//   misses and all stores raise StallReqM, run one req/ack transaction to
//   backing memory, then spend one RESUME cycle handing the result to the
//   W-stage register before the pipeline is released.
//
// Ports
//   clk, rst_n          core clock, async active-low reset
//   MemReadM/MemWriteM  M-stage load/store strobes (store wins if both)
//   AddrM, WriteDataM   M-stage byte address and store data
//   ReadDataM           load data (hit data in IDLE, refill data in RESUME)
//   StallReqM           freeze request to the hazard unit
//   mem_req/we/addr/wdata  registered backing-memory request
//   mem_rdata, mem_ack  backing-memory response (ack is a 1-cycle strobe)
//   perf_hits/misses    wrapping load hit / miss counters

// One cache line: valid (reset), tag and data (not reset).
module dcache_line #(
  parameter int TW = 26,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill_en,
  input  logic [TW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  input  logic          upd_en,
  input  logic [DW-1:0] upd_data,
  output logic          vld,
  output logic [TW-1:0] tag,
  output logic [DW-1:0] data
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       vld <= 1'b0;
    else if (fill_en) vld <= 1'b1;

  always_ff @(posedge clk)
    if (fill_en) begin
      tag  <= fill_tag;
      data <= fill_data;
    end else if (upd_en) begin
      data <= upd_data;
    end
endmodule

module dcache_stall_ctrl #(
  parameter int LINES      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PERF_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [31:0]           AddrM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallReqM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [PERF_WIDTH-1:0] perf_hits,
  output logic [PERF_WIDTH-1:0] perf_misses
);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - IB;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESUME} state_t;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
  } mreq_t;

  state_t state, state_nxt;
  mreq_t  mreq_q;
  logic [DATA_WIDTH-1:0] hold_q;

  // Address split for the live M-stage access.
  logic [IB-1:0] idx_m;
  logic [TW-1:0] tag_m;
  assign idx_m = AddrM[IB+1:2];
  assign tag_m = AddrM[31:IB+2];

  // Byte offset is not used: accesses are word only.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^AddrM[1:0];

  // Refill targets the latched address, not AddrM.
  logic [IB-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  assign fill_idx = mreq_q.addr[IB+1:2];
  assign fill_tag = mreq_q.addr[31:IB+2];

  logic [LINES-1:0]                 line_vld;
  logic [LINES-1:0][TW-1:0]         line_tag;
  logic [LINES-1:0][DATA_WIDTH-1:0] line_data;

  logic hit, idle, st_det, ld_det, ld_hit, ld_miss, st_hit, refill;
  assign hit     = line_vld[idx_m] & (line_tag[idx_m] == tag_m);
  assign idle    = (state == IDLE);
  assign st_det  = idle & MemWriteM;
  assign ld_det  = idle & MemReadM & ~MemWriteM;
  assign ld_hit  = ld_det & hit;
  assign ld_miss = ld_det & ~hit;
  assign st_hit  = st_det & hit;
  assign refill  = (state == RD_WAIT) & mem_ack;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    logic fill_sel, upd_sel;
    assign fill_sel = refill & (fill_idx == IB'(i));
    assign upd_sel  = st_hit & (idx_m == IB'(i));

    dcache_line #(.TW(TW), .DW(DATA_WIDTH)) u_line (
      .clk       (clk),
      .rst_n     (rst_n),
      .fill_en   (fill_sel),
      .fill_tag  (fill_tag),
      .fill_data (mem_rdata),
      .upd_en    (upd_sel),
      .upd_data  (WriteDataM),
      .vld       (line_vld[i]),
      .tag       (line_tag[i]),
      .data      (line_data[i])
    );
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st_det)       state_nxt = WR_WAIT;
               else if (ld_miss) state_nxt = RD_WAIT;
      RD_WAIT: if (mem_ack)      state_nxt = RESUME;
      WR_WAIT: if (mem_ack)      state_nxt = RESUME;
      RESUME:                    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Stall is gated by rst_n so it drops the instant reset
  // asserts even while the pipeline still presents a load/store.
  always_comb begin
    StallReqM = 1'b0;
    ReadDataM = '0;
    case (state)
      IDLE: begin
        StallReqM = st_det | ld_miss;
        if (ld_hit) ReadDataM = line_data[idx_m];
      end
      RD_WAIT, WR_WAIT: StallReqM = 1'b1;
      // Same instruction still in M: return its result, ignore strobes.
      RESUME: if (!mreq_q.we) ReadDataM = hold_q;
      default: ;
    endcase
    StallReqM = StallReqM & rst_n;
  end

  // Memory request register. mem_we keeps the last direction after ack so
  // RESUME knows whether it is finishing a read or a write.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mreq_q <= '0;
      hold_q <= '0;
    end else begin
      if (st_det | ld_miss) begin
        mreq_q.req  <= 1'b1;
        mreq_q.we   <= st_det;
        mreq_q.addr <= {AddrM[31:2], 2'b00};
        if (st_det) mreq_q.wdata <= WriteDataM;
      end else if (mem_ack && (state == RD_WAIT || state == WR_WAIT)) begin
        mreq_q.req <= 1'b0;
      end
      if (refill) hold_q <= mem_rdata;
    end

  assign mem_req   = mreq_q.req;
  assign mem_we    = mreq_q.we;
  assign mem_addr  = mreq_q.addr;
  assign mem_wdata = mreq_q.wdata;

  // Load-only performance counters; wrap naturally.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (ld_hit)  perf_hits   <= perf_hits + PERF_WIDTH'(1);
      if (ld_miss) perf_misses <= perf_misses + PERF_WIDTH'(1);
    end
endmodule
